mem_unit: RTL and testbench
===========================

MEM_UNIT -- requirements
Module: mem_unit

Interface
REQ-001 Parameter ADDR_W, default 8, word-index width; RAM depth is 2^ADDR_W 32-bit words.
REQ-002 Parameter WAIT, default 2, extra wait cycles per access, legal range 0..7.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  active-low, synchronous reset, sampled on the rising edge of clk.
REQ-005 mem_read  input  1  read request from the control FSM.
REQ-006 mem_write  input  1  write request from the control FSM.
REQ-007 iord  input  1  address select: 0 = pc, 1 = alu_out.
REQ-008 pc  input  32  byte address used for instruction fetch.
REQ-009 alu_out  input  32  byte address used for data access.
REQ-010 wdata  input  32  store data (register B).
REQ-011 ir_write  input  1  the read result also loads ir.
REQ-012 load_en  input  1  program-load write strobe.
REQ-013 load_addr  input  ADDR_W  program-load word index.
REQ-014 load_data  input  32  program-load data.
REQ-015 ir  output  32  instruction register.
REQ-016 mdr  output  32  memory data register.
REQ-017 busy  output  1  high while an access is in flight.
REQ-018 done  output  1  one-cycle pulse marking access completion.
REQ-019 misalign  output  1  sticky flag: an access used a non-word-aligned address.
REQ-020 conflict  output  1  sticky flag: mem_read and mem_write were sampled high together.
REQ-021 rd_count  output  16  count of completed reads.
REQ-022 wr_count  output  16  count of completed writes, loader writes excluded.

Function
REQ-023 FSM states SHALL be IDLE and ACCESS; only IDLE accepts requests.
REQ-024 In IDLE, mem_read or mem_write high at an edge (with load_en low) SHALL perform all of the following at that same edge:
- capture the address (pc if iord=0, else alu_out);
- capture wdata, ir_write and the operation;
- load the wait counter with WAIT;
- enter ACCESS.
REQ-025 In ACCESS the counter SHALL decrement once per edge; the edge at which the counter reads 0 is the completion edge, at which the block performs the operation, pulses done and returns to IDLE.
REQ-026 Completion SHALL occur exactly WAIT+1 edges after the accepting edge; busy SHALL equal (state==ACCESS).
REQ-027 Read completion: mdr <= mem[addr[ADDR_W+1:2]]; additionally ir <= the same word when the captured ir_write=1; rd_count increments.
REQ-028 Write completion: mem[addr[ADDR_W+1:2]] <= captured wdata; wr_count increments; mdr and ir are unchanged.
REQ-029 Address bits above ADDR_W+1 SHALL be ignored, so word indices wrap modulo 2^ADDR_W.
REQ-030 If captured addr[1:0]!=0, the block SHALL NOT touch RAM, mdr, ir or the counters at completion; it SHALL set misalign, and done still pulses.
REQ-031 mem_read and mem_write both high at acceptance SHALL set conflict and be treated as a write.
REQ-032 Requests, ir_write and load_en sampled while busy=1 SHALL be ignored, with no queuing.
REQ-033 In IDLE, load_en=1 SHALL write load_data to mem[load_addr] at that edge, take priority over mem_read/mem_write (the request is dropped), leave busy low, and not pulse done.
REQ-034 rd_count and wr_count SHALL saturate at 16'hFFFF.
REQ-035 done SHALL be registered, high for exactly one cycle per completed access, and never high in two consecutive cycles.
REQ-036 mdr and ir SHALL hold their values between completions.

Reset
REQ-037 rst=0 at an edge SHALL set state to IDLE and set busy, done, misalign and conflict to 0, ir, mdr, rd_count and wr_count to 0, and the wait counter to 0.
REQ-038 Reset SHALL NOT clear RAM contents.
REQ-039 Reset asserted during ACCESS SHALL abort the access: no RAM write occurs and mdr and ir are unchanged apart from being cleared to 0.
REQ-040 Reset SHALL take priority over load_en and over any request.

Verification
REQ-041 Load mem[0]=32'h8C010004 via load_en, then mem_read=1, iord=0, pc=0, ir_write=1 at edge 1 (WAIT=2) -> busy high after edges 1-3, done pulse and ir=mdr=32'h8C010004 after edge 4, rd_count=1.
REQ-042 mem_write=1, iord=1, alu_out=32'h10, wdata=32'hDEADBEEF, then read of the same address -> mdr=32'hDEADBEEF, wr_count=1, ir unchanged.
REQ-043 Read with alu_out=32'h6 -> misalign=1, done pulses, mdr unchanged, rd_count unchanged; the flag stays 1 until reset.
REQ-044 mem_write=1 with mem_read=1 -> conflict=1 and write performed; a new request while busy -> ignored, exactly one done pulse.
REQ-045 rst=0 one edge after a write is accepted -> all outputs 0 and the target RAM word retains its old value; with WAIT=0 the next access completes one edge after acceptance.
REQ-046 Address 32'h400 with ADDR_W=8 -> accesses word 0 (wrap).

Source files
------------

// File: rtl/mem_unit_if.sv
// Request/response bundle between the control FSM and mem_unit.
// Latency: none (wires only). Backpressure: the master must watch busy; requests seen while busy are dropped.
// Ports: master drives the request/loader fields, slave drives ir/mdr/status/counters.
interface mem_unit_if #(
  parameter int ADDR_W = 8
);
  // request side
  logic              mem_read;
  logic              mem_write;
  logic              iord;
  logic [31:0]       pc;
  logic [31:0]       alu_out;
  logic [31:0]       wdata;
  logic              ir_write;
  // program loader
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  // response / status
  logic [31:0]       ir;
  logic [31:0]       mdr;
  logic              busy;
  logic              done;
  logic              misalign;
  logic              conflict;
  logic [15:0]       rd_count;
  logic [15:0]       wr_count;

  modport master (
    output mem_read, mem_write, iord, pc, alu_out, wdata, ir_write,
           load_en, load_addr, load_data,
    input  ir, mdr, busy, done, misalign, conflict, rd_count, wr_count
  );

  modport slave (
    input  mem_read, mem_write, iord, pc, alu_out, wdata, ir_write,
           load_en, load_addr, load_data,
    output ir, mdr, busy, done, misalign, conflict, rd_count, wr_count
  );
endinterface

// File: rtl/mem_unit.sv
// Word-addressed unified instruction/data RAM with fixed wait states, ir/mdr capture and status counters.
// Latency: completion (done pulse, RAM/mdr/ir update) exactly WAIT+1 edges after the accepting edge.
// Backpressure: one access in flight; requests, ir_write and load_en arriving while busy are dropped.
// Ports: clk, rst (sync, active low), bus (mem_unit_if.slave: requests, loader, ir/mdr/status outputs).
module mem_unit #(
  parameter int ADDR_W = 8,
  parameter int WAIT   = 2
) (
  input  logic       clk,
  input  logic       rst,
  mem_unit_if.slave  bus
);
  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [2:0] WAIT_INIT = 3'(WAIT);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        wait_cnt;
  logic [ADDR_W+1:0] addr;      // only the bits that select a word plus the alignment bits
  logic [31:0]       wdata_q;
  logic              irw_q;
  logic              op_write;

  logic [31:0]       ram [DEPTH];

  logic [31:0]       sel_addr;
  logic              unused_addr_bits;
  logic              accept;
  logic              complete;
  logic              aligned;
  logic [ADDR_W-1:0] idx;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [31:0]       ram_wdata;

  assign sel_addr = bus.iord ? bus.alu_out : bus.pc;
  // Upper byte-address bits are deliberately discarded so word indices wrap.
  assign unused_addr_bits = ^sel_addr[31:ADDR_W+2];

  // Loader wins over a request presented in the same IDLE cycle.
  assign accept   = (state == IDLE) && !bus.load_en && (bus.mem_read || bus.mem_write);
  assign complete = (state == ACCESS) && (wait_cnt == 3'd0);
  assign aligned  = (addr[1:0] == 2'b00);
  assign idx      = addr[ADDR_W+1:2];

  assign bus.busy = (state == ACCESS);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = ACCESS;
      ACCESS:  if (complete) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single RAM write port shared by the loader and store completion; both
  // are gated by reset so an aborted access never lands in memory.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = bus.load_addr;
    ram_wdata = bus.load_data;
    if (rst) begin
      if (state == IDLE && bus.load_en) begin
        ram_we = 1'b1;
      end else if (complete && op_write && aligned) begin
        ram_we    = 1'b1;
        ram_waddr = idx;
        ram_wdata = wdata_q;
      end
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt     <= 3'd0;
      addr         <= '0;
      wdata_q      <= 32'd0;
      irw_q        <= 1'b0;
      op_write     <= 1'b0;
      bus.ir       <= 32'd0;
      bus.mdr      <= 32'd0;
      bus.done     <= 1'b0;
      bus.misalign <= 1'b0;
      bus.conflict <= 1'b0;
      bus.rd_count <= 16'd0;
      bus.wr_count <= 16'd0;
    end else begin
      bus.done <= 1'b0;
      if (accept) begin
        addr     <= sel_addr[ADDR_W+1:0];
        wdata_q  <= bus.wdata;
        irw_q    <= bus.ir_write;
        op_write <= bus.mem_write;  // read+write together resolves to a write
        wait_cnt <= WAIT_INIT;
        if (bus.mem_read && bus.mem_write) bus.conflict <= 1'b1;
      end else if (state == ACCESS) begin
        if (wait_cnt != 3'd0) begin
          wait_cnt <= wait_cnt - 3'd1;
        end else begin
          bus.done <= 1'b1;
          if (!aligned) begin
            bus.misalign <= 1'b1;
          end else if (op_write) begin
            if (bus.wr_count != 16'hFFFF) bus.wr_count <= bus.wr_count + 16'd1;
          end else begin
            bus.mdr <= ram[idx];
            if (irw_q) bus.ir <= ram[idx];
            if (bus.rd_count != 16'hFFFF) bus.rd_count <= bus.rd_count + 16'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_unit.sv
// Self-checking bench for mem_unit: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model (completion edge = accept edge + WAIT + 1).
module tb_mem_unit;
  localparam int AW    = 8;
  localparam int WT    = 2;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_unit_if #(.ADDR_W(AW)) bus ();
  mem_unit_if #(.ADDR_W(AW)) bus0 ();

  mem_unit #(.ADDR_W(AW), .WAIT(WT)) dut  (.clk(clk), .rst(rst), .bus(bus));
  mem_unit #(.ADDR_W(AW), .WAIT(0))  dut0 (.clk(clk), .rst(rst), .bus(bus0));

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_ir = 0, m_mdr = 0;
  bit          m_busy = 0, m_done = 0, m_mis = 0, m_conf = 0;
  int          m_rd = 0, m_wr = 0;
  logic [31:0] p_addr, p_wd;
  bit          p_irw, p_wr;
  longint      p_due = 0;
  longint      edge_no = 0;

  task automatic model_step();
    int widx;
    if (!rst) begin
      m_busy = 0; m_done = 0; m_mis = 0; m_conf = 0;
      m_ir = 0; m_mdr = 0; m_rd = 0; m_wr = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        if (edge_no == p_due) begin
          widx = int'((p_addr >> 2) % DEPTH);
          if (p_addr % 4 != 0) m_mis = 1;
          else if (p_wr) begin
            m_mem[widx] = p_wd;
            if (m_wr < 65535) m_wr++;
          end else begin
            m_mdr = m_mem[widx];
            if (p_irw) m_ir = m_mdr;
            if (m_rd < 65535) m_rd++;
          end
          m_done = 1;
          m_busy = 0;
        end
      end else if (bus.load_en) begin
        m_mem[bus.load_addr] = bus.load_data;
      end else if (bus.mem_read || bus.mem_write) begin
        p_addr = bus.iord ? bus.alu_out : bus.pc;
        p_wd   = bus.wdata;
        p_irw  = bus.ir_write;
        p_wr   = bus.mem_write;
        if (bus.mem_read && bus.mem_write) m_conf = 1;
        p_due  = edge_no + WT + 1;
        m_busy = 1;
      end
    end
    edge_no++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("busy",     {31'd0, bus.busy},     {31'd0, m_busy});
      chk("done",     {31'd0, bus.done},     {31'd0, m_done});
      chk("misalign", {31'd0, bus.misalign}, {31'd0, m_mis});
      chk("conflict", {31'd0, bus.conflict}, {31'd0, m_conf});
      chk("ir",       bus.ir,                m_ir);
      chk("mdr",      bus.mdr,               m_mdr);
      chk("rd_count", {16'd0, bus.rd_count}, 32'(m_rd));
      chk("wr_count", {16'd0, bus.wr_count}, 32'(m_wr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.mem_read = 0; bus.mem_write = 0; bus.iord = 0; bus.ir_write = 0;
    bus.pc = 0; bus.alu_out = 0; bus.wdata = 0;
    bus.load_en = 0; bus.load_addr = 0; bus.load_data = 0;
  endtask

  task automatic idle0();
    bus0.mem_read = 0; bus0.mem_write = 0; bus0.iord = 0; bus0.ir_write = 0;
    bus0.pc = 0; bus0.alu_out = 0; bus0.wdata = 0;
    bus0.load_en = 0; bus0.load_addr = 0; bus0.load_data = 0;
  endtask

  task automatic req(input bit rd, input bit wr, input bit io, input logic [31:0] a,
                     input logic [31:0] wd, input bit irw);
    bus.mem_read = rd; bus.mem_write = wr; bus.iord = io;
    bus.pc      = io ? $urandom : a;
    bus.alu_out = io ? a : $urandom;
    bus.wdata = wd; bus.ir_write = irw;
  endtask

  // One request, then wait (bounded) for its done pulse and check the latency.
  task automatic access(input bit rd, input bit wr, input bit io, input logic [31:0] a,
                        input logic [31:0] wd, input bit irw);
    int e;
    req(rd, wr, io, a, wd, irw);
    tick();
    idle();
    e = 0;
    do begin
      tick();
      e++;
    end while (bus.done !== 1'b1 && e < 20);
    chk("latency", 32'(e), 32'(WT + 1));
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
    if ($urandom_range(0, 3) != 0) a[31:10] = '0;
    return a;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int ndone;
    idle();
    idle0();
    rst = 0;
    repeat (3) tick();
    chk("rst_busy",  {31'd0, bus.busy}, 0);
    chk("rst_done",  {31'd0, bus.done}, 0);
    chk("rst_ir",    bus.ir, 0);
    chk("rst_mdr",   bus.mdr, 0);
    chk("rst_rdcnt", {16'd0, bus.rd_count}, 0);
    chk("rst_wrcnt", {16'd0, bus.wr_count}, 0);
    chk("rst_flags", {30'd0, bus.misalign, bus.conflict}, 0);
    rst = 1;
    chk_en = 1;

    // program load; word 6 carries a marker for the aborted-write test
    for (int i = 0; i < DEPTH; i++) begin
      bus.load_en   = 1;
      bus.load_addr = AW'(i);
      bus.load_data = (i == 0) ? 32'h8C010004 : (i == 6) ? 32'h66666666 : $urandom;
      bus0.load_en   = (i == 3);
      bus0.load_addr = 8'd3;
      bus0.load_data = 32'hA5A50003;
      tick();
    end
    idle();
    idle0();

    // instruction fetch, WAIT=2: busy after edges 1..3, done after edge 4
    req(1, 0, 0, 32'h0, 32'h0, 1);
    tick();
    idle();
    chk("fetch_busy_e1", {31'd0, bus.busy}, 1);
    tick();
    chk("fetch_busy_e2", {31'd0, bus.busy}, 1);
    tick();
    chk("fetch_busy_e3", {31'd0, bus.busy}, 1);
    chk("fetch_done_e3", {31'd0, bus.done}, 0);
    tick();
    chk("fetch_done_e4", {31'd0, bus.done}, 1);
    chk("fetch_busy_e4", {31'd0, bus.busy}, 0);
    chk("fetch_ir",      bus.ir,  32'h8C010004);
    chk("fetch_mdr",     bus.mdr, 32'h8C010004);
    chk("fetch_rdcnt",   {16'd0, bus.rd_count}, 1);
    chk("model_ir",      m_ir, 32'h8C010004);
    tick();
    chk("done_one_cycle", {31'd0, bus.done}, 0);

    // store then load back the same word
    access(0, 1, 1, 32'h10, 32'hDEADBEEF, 0);
    chk("store_wrcnt", {16'd0, bus.wr_count}, 1);
    access(1, 0, 1, 32'h10, 32'h0, 0);
    chk("load_mdr",   bus.mdr, 32'hDEADBEEF);
    chk("load_ir_kept", bus.ir, 32'h8C010004);
    chk("model_mdr",  m_mdr, 32'hDEADBEEF);

    // misaligned read: flag set, nothing else changes
    access(1, 0, 1, 32'h6, 32'h0, 1);
    chk("mis_flag",  {31'd0, bus.misalign}, 1);
    chk("mis_mdr",   bus.mdr, 32'hDEADBEEF);
    chk("mis_ir",    bus.ir, 32'h8C010004);
    chk("mis_rdcnt", {16'd0, bus.rd_count}, 2);
    repeat (3) tick();
    chk("mis_sticky", {31'd0, bus.misalign}, 1);

    // address wrap: byte 0x400 is word 0
    access(1, 0, 1, 32'h400, 32'h0, 0);
    chk("wrap_mdr", bus.mdr, 32'h8C010004);

    // read+write together is a write; a request while busy is dropped
    req(1, 1, 1, 32'h14, 32'h12345678, 0);
    tick();
    chk("conflict_flag", {31'd0, bus.conflict}, 1);
    req(1, 0, 1, 32'h20, 32'h0, 1);
    ndone = 0;
    tick(); ndone += int'(bus.done);
    tick(); ndone += int'(bus.done);
    idle();
    repeat (6) begin
      tick();
      ndone += int'(bus.done);
    end
    chk("single_done",    32'(ndone), 1);
    chk("conflict_wrcnt", {16'd0, bus.wr_count}, 2);
    access(1, 0, 1, 32'h14, 32'h0, 0);
    chk("conflict_data",  bus.mdr, 32'h12345678);

    // reset one edge after a write is accepted: abort, RAM keeps old word
    req(0, 1, 1, 32'h18, 32'hBADBAD00, 0);
    tick();
    rst = 0;
    idle();
    tick();
    chk("abort_busy",  {31'd0, bus.busy}, 0);
    chk("abort_ir",    bus.ir, 0);
    chk("abort_mdr",   bus.mdr, 0);
    chk("abort_cnts",  {bus.rd_count, bus.wr_count}, 0);
    chk("abort_flags", {29'd0, bus.misalign, bus.conflict, bus.done}, 0);
    rst = 1;
    access(1, 0, 1, 32'h18, 32'h0, 0);
    chk("abort_ram_kept", bus.mdr, 32'h66666666);

    // WAIT=0 instance: completes one edge after acceptance
    bus0.mem_read = 1; bus0.pc = 32'hC; bus0.ir_write = 1;
    tick();
    idle0();
    chk("w0_busy_accept", {31'd0, bus0.busy}, 1);
    chk("w0_done_accept", {31'd0, bus0.done}, 0);
    tick();
    chk("w0_done",  {31'd0, bus0.done}, 1);
    chk("w0_busy",  {31'd0, bus0.busy}, 0);
    chk("w0_mdr",   bus0.mdr, 32'hA5A50003);
    chk("w0_ir",    bus0.ir,  32'hA5A50003);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 299) != 0);
      bus.load_en   = ($urandom_range(0, 15) == 0);
      bus.load_addr = AW'($urandom);
      bus.load_data = $urandom;
      bus.mem_read  = ($urandom_range(0, 2) == 0);
      bus.mem_write = ($urandom_range(0, 3) == 0);
      bus.iord      = 1'($urandom);
      bus.pc        = rnd_addr();
      bus.alu_out   = rnd_addr();
      bus.wdata     = $urandom;
      bus.ir_write  = 1'($urandom);
      tick();
    end
    rst = 1;
    idle();
    repeat (10) tick();
    chk_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
